// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback queue.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package wb_pkg;

    localparam int REG_W  = 3;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match operand forwarding for one register file read port.
// Latency: purely combinational.
// Backpressure: none; always produces a value (queue data or raw register file data).
//
// Ports:
//   entries  queue storage, indexed by physical slot
//   valid    per-slot occupancy mask
//   head     slot of the oldest pending entry
//   rdReg    read address presented to the register file
//   rfVal    raw register file read data
//   fwdVal   forwarded operand value
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [REG_W-1:0]           rdReg,
    input  logic [DATA_W-1:0]          rfVal,
    output logic [DATA_W-1:0]          fwdVal
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk slots from oldest (head) to youngest; a later match overrides an
    // earlier one, so the last hit is the entry nearest tail.
    always_comb begin
        fwdVal = rfVal;
        idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (entries[idx].rd == rdReg)) begin
                fwdVal = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue between execute/memory and the register file write port,
// with forwarding of pending results onto both register file read ports.
// Latency: push at edge N is writable/forwardable in cycle N+1; one push and one pop per cycle.
// Backpressure: wbReady low only when all DEPTH slots are full (a same-cycle pop does not help).
//
// Ports:
//   CLK, RSTn                      clock, async active-low reset
//   wbValid/wbReg/wbData/wbReady   result push interface
//   drainEn                        register file write port free this cycle
//   regWrite/wrReg/writeValue      register file write port (head entry)
//   rdReg1/2, rfVal1/2             register file read addresses and raw data
//   fwdVal1/2, fwdCmp              forwarded operands and zero flag of operand 1
//   count, empty                   occupancy
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     wbValid,
    input  logic [REG_W-1:0]         wbReg,
    input  logic [DATA_W-1:0]        wbData,
    output logic                     wbReady,
    input  logic                     drainEn,
    output logic                     regWrite,
    output logic [REG_W-1:0]         wrReg,
    output logic [DATA_W-1:0]        writeValue,
    input  logic [REG_W-1:0]         rdReg1,
    input  logic [REG_W-1:0]         rdReg2,
    input  logic [DATA_W-1:0]        rfVal1,
    input  logic [DATA_W-1:0]        rfVal2,
    output logic [DATA_W-1:0]        fwdVal1,
    output logic [DATA_W-1:0]        fwdVal2,
    output logic                     fwdCmp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        entries_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    offset;

    assign wbReady    = (count_q < CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign push       = wbValid && wbReady;
    assign regWrite   = !empty && drainEn;
    assign pop        = regWrite;
    assign wrReg      = entries_q[head_q].rd;
    assign writeValue = entries_q[head_q].data;
    assign count      = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is not reset; occupancy is tracked entirely by head/count.
    always_ff @(posedge CLK) begin
        if (push) begin
            entries_q[tail_q] <= '{rd: wbReg, data: wbData};
        end
    end

    // A slot is occupied when its distance from head (mod DEPTH) is below count.
    // The head slot stays valid during the cycle it drains.
    always_comb begin
        valid  = '0;
        offset = '0;
        for (int j = 0; j < DEPTH; j++) begin
            offset   = PW'(j) - head_q;
            valid[j] = ({1'b0, offset} < count_q);
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .entries (entries_q),
        .valid   (valid),
        .head    (head_q),
        .rdReg   (rdReg1),
        .rfVal   (rfVal1),
        .fwdVal  (fwdVal1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .entries (entries_q),
        .valid   (valid),
        .head    (head_q),
        .rdReg   (rdReg2),
        .rfVal   (rfVal2),
        .fwdVal  (fwdVal2)
    );

    assign fwdCmp = (fwdVal1 == '0);

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_queue;

    logic       CLK = 1'b0;
    logic       RSTn;
    logic       wbValid;
    logic [2:0] wbReg;
    logic [7:0] wbData;
    logic       wbReady;
    logic       drainEn;
    logic       regWrite;
    logic [2:0] wrReg;
    logic [7:0] writeValue;
    logic [2:0] rdReg1, rdReg2;
    logic [7:0] rfVal1, rfVal2;
    logic [7:0] fwdVal1, fwdVal2;
    logic       fwdCmp;
    logic [2:0] count;
    logic       empty;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q [$];
    logic [10:0] front;

    always #5 CLK = ~CLK;

    wb_queue #(.DEPTH(4)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .wbValid    (wbValid),
        .wbReg      (wbReg),
        .wbData     (wbData),
        .wbReady    (wbReady),
        .drainEn    (drainEn),
        .regWrite   (regWrite),
        .wrReg      (wrReg),
        .writeValue (writeValue),
        .rdReg1     (rdReg1),
        .rdReg2     (rdReg2),
        .rfVal1     (rfVal1),
        .rfVal2     (rfVal2),
        .fwdVal1    (fwdVal1),
        .fwdVal2    (fwdVal2),
        .fwdCmp     (fwdCmp),
        .count      (count),
        .empty      (empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTn    = 1'b0;
        wbValid = 1'b0;
        wbReg   = '0;
        wbData  = '0;
        drainEn = 1'b0;
        rdReg1  = 3'd0;
        rdReg2  = 3'd0;
        rfVal1  = 8'h55;
        rfVal2  = 8'h66;
        #2;
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_regwrite", 32'(regWrite), 32'd0);
        chk("rst_ready",    32'(wbReady),  32'd1);
        chk("rst_fwd1",     32'(fwdVal1),  32'h55);
        tick();
        RSTn = 1'b1;
        tick();

        // Basic write: r3=A5 pushed, written the following cycle.
        wbValid = 1'b1; wbReg = 3'd3; wbData = 8'hA5; drainEn = 1'b1;
        #1;
        chk("bw_no_bypass", 32'(regWrite), 32'd0);
        tick();
        wbValid = 1'b0;
        #1;
        chk("bw_regwrite", 32'(regWrite),   32'd1);
        chk("bw_wrreg",    32'(wrReg),      32'd3);
        chk("bw_value",    32'(writeValue), 32'hA5);
        chk("bw_count",    32'(count),      32'd1);
        tick();
        chk("bw_empty",    32'(empty),      32'd1);
        chk("bw_idle",     32'(regWrite),   32'd0);

        // Fill to full with drain disabled.
        drainEn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wbValid = 1'b1; wbReg = 3'(4 + k); wbData = 8'((k + 1) * 16);
            exp_q.push_back({wbReg, wbData});
            tick();
        end
        wbReg = 3'd1; wbData = 8'hEE;
        #1;
        chk("full_ready", 32'(wbReady), 32'd0);
        chk("full_count", 32'(count),   32'd4);
        tick();
        chk("full_ignored", 32'(count), 32'd4);

        // One pop to leave room, then sustained push+pop across pointer wrap.
        wbValid = 1'b0; drainEn = 1'b1;
        #1;
        front = exp_q[0];
        chk("drain0_val", 32'(writeValue), 32'(front[7:0]));
        tick();
        void'(exp_q.pop_front());
        chk("drain0_count", 32'(count), 32'd3);
        for (int k = 0; k < 10; k++) begin
            wbValid = 1'b1; wbReg = 3'(k); wbData = 8'(8'h50 + k);
            #1;
            front = exp_q[0];
            chk("wrap_reg",   32'(wrReg),      32'(front[10:8]));
            chk("wrap_val",   32'(writeValue), 32'(front[7:0]));
            chk("wrap_count", 32'(count),      32'd3);
            chk("wrap_ready", 32'(wbReady),    32'd1);
            exp_q.push_back({wbReg, wbData});
            tick();
            void'(exp_q.pop_front());
        end
        wbValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            front = exp_q[0];
            chk("tail_reg", 32'(wrReg),      32'(front[10:8]));
            chk("tail_val", 32'(writeValue), 32'(front[7:0]));
            tick();
            void'(exp_q.pop_front());
        end
        chk("wrap_empty", 32'(empty), 32'd1);

        // Forwarding priority: youngest of two r2 entries wins.
        drainEn = 1'b0;
        wbValid = 1'b1; wbReg = 3'd2; wbData = 8'h11;
        tick();
        wbData = 8'h22;
        tick();
        wbValid = 1'b0;
        rdReg1 = 3'd2; rfVal1 = 8'h00;
        rdReg2 = 3'd2; rfVal2 = 8'h77;
        #1;
        chk("fwd_young1", 32'(fwdVal1), 32'h22);
        chk("fwd_cmp0",   32'(fwdCmp),  32'd0);
        chk("fwd_young2", 32'(fwdVal2), 32'h22);
        rdReg2 = 3'd3;
        #1;
        chk("fwd_miss2",  32'(fwdVal2), 32'h77);
        drainEn = 1'b1;
        tick();
        chk("fwd_after1", 32'(fwdVal1), 32'h22);
        tick();
        chk("fwd_gone",   32'(fwdVal1), 32'h00);
        chk("fwd_empty",  32'(empty),   32'd1);

        // Zero flag from a pending zero value, then continuity after drain.
        drainEn = 1'b0;
        wbValid = 1'b1; wbReg = 3'd5; wbData = 8'h00;
        rdReg1 = 3'd5; rfVal1 = 8'h07;
        tick();
        wbValid = 1'b0;
        #1;
        chk("zf_pending", 32'(fwdCmp), 32'd1);
        drainEn = 1'b1;
        #1;
        chk("zf_draining", 32'(fwdCmp),   32'd1);
        chk("zf_regwrite", 32'(regWrite), 32'd1);
        tick();
        rfVal1 = 8'h00;
        #1;
        chk("zf_after", 32'(fwdCmp), 32'd1);
        chk("zf_empty", 32'(empty),  32'd1);

        // Value offered this cycle is not forwarded until the next.
        drainEn = 1'b0;
        wbValid = 1'b1; wbReg = 3'd1; wbData = 8'h9C;
        rdReg1 = 3'd1; rfVal1 = 8'h33;
        #1;
        chk("same_cycle", 32'(fwdVal1), 32'h33);
        tick();
        wbValid = 1'b0;
        #1;
        chk("next_cycle", 32'(fwdVal1), 32'h9C);

        // Mid-stream asynchronous reset with 3 entries pending.
        wbValid = 1'b1; wbReg = 3'd1; wbData = 8'hAA;
        tick();
        wbReg = 3'd2; wbData = 8'hBB;
        tick();
        wbValid = 1'b0;
        #1;
        chk("pre_rst_count", 32'(count), 32'd3);
        drainEn = 1'b1; rfVal1 = 8'h55;
        RSTn = 1'b0;
        #1;
        chk("mrst_count",    32'(count),    32'd0);
        chk("mrst_regwrite", 32'(regWrite), 32'd0);
        chk("mrst_ready",    32'(wbReady),  32'd1);
        chk("mrst_empty",    32'(empty),    32'd1);
        tick();
        RSTn = 1'b1;
        #1;
        chk("post_rst_fwd1", 32'(fwdVal1), 32'h55);
        tick();
        chk("post_rst_regwrite", 32'(regWrite), 32'd0);
        chk("post_rst_count",    32'(count),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
